// File: rtl/ex_madd_unit_if.sv
// Bus between the EX stage / ctrl and the multiply-accumulate engine.
// master = EX/ctrl side, slave = ex_madd_unit.
interface ex_madd_unit_if #(
  parameter int DATA_W = 32
);
  logic              flush;
  logic [5:0]        stall;
  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] reg1_i;
  logic [DATA_W-1:0] reg2_i;
  logic [DATA_W-1:0] hi_i;
  logic [DATA_W-1:0] lo_i;
  logic              stallreq_o;
  logic              whilo_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;
  logic [1:0]        cnt_o;

  modport master (
    output flush, stall, start, op, reg1_i, reg2_i, hi_i, lo_i,
    input  stallreq_o, whilo_o, hi_o, lo_o, cnt_o
  );

  modport slave (
    input  flush, stall, start, op, reg1_i, reg2_i, hi_i, lo_i,
    output stallreq_o, whilo_o, hi_o, lo_o, cnt_o
  );
endinterface

// File: rtl/ex_madd_unit.sv
// Multi-cycle MADD/MADDU/MSUB/MSUBU engine: {HI,LO} <= {HI,LO} +/- reg1*reg2.
// Define MADD_SPLIT_MUL_EN to split the multiply over two half-width cycles.
module ex_madd_unit #(
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  ex_madd_unit_if.slave bus
);

  localparam int PW   = 2 * DATA_W;
  localparam int HALF = DATA_W / 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MUL    = 3'd1,
    S_ACC    = 3'd2,
    S_HOLD   = 3'd3,
    S_MUL_HI = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, b_q;
  logic [1:0]        op_q;
  logic [PW-1:0]     base_q, prod_q, res_q;
  logic [PW-1:0]     prod_d, res;
  logic              go;

  // Low PW bits of the product of the extended operands equal the exact
  // signed/unsigned product modulo 2^PW.
  function automatic logic [PW-1:0] mul_full(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b,
                                             input logic              uns);
    logic signed [PW-1:0] ea, eb;
    ea = uns ? {{DATA_W{1'b0}}, a} : {{DATA_W{a[DATA_W-1]}}, a};
    eb = uns ? {{DATA_W{1'b0}}, b} : {{DATA_W{b[DATA_W-1]}}, b};
    return ea * eb;
  endfunction

  function automatic logic [PW-1:0] acc_wrap(input logic [PW-1:0] base,
                                             input logic [PW-1:0] prod,
                                             input logic          sub);
    return sub ? (base - prod) : (base + prod);
  endfunction

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x,
                                            input logic              uns);
    return (uns || !x[DATA_W-1]) ? x : (~x + 1'b1);
  endfunction

  assign go  = bus.start & ~bus.flush & rst;
  assign res = acc_wrap(base_q, prod_q, op_q[1]);

`ifdef MADD_SPLIT_MUL_EN
  logic [DATA_W-1:0] mag_a, mag_b;
  logic [PW-1:0]     sum_hi;
  logic              neg;

  always_comb begin
    mag_a  = mag(a_q, op_q[0]);
    mag_b  = mag(b_q, op_q[0]);
    neg    = ~op_q[0] & (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
    sum_hi = prod_q + ((PW'(mag_a) * PW'(mag_b[DATA_W-1:HALF])) << HALF);
    prod_d = prod_q;
    if (state_q == S_MUL)
      prod_d = PW'(mag_a) * PW'(mag_b[HALF-1:0]);
    else if (state_q == S_MUL_HI)
      prod_d = neg ? (~sum_hi + 1'b1) : sum_hi;
  end
`else
  logic [DATA_W-1:0] unused_mag;
  assign unused_mag = mag(a_q, 1'b1);

  always_comb begin
    prod_d = prod_q;
    if (state_q == S_MUL)
      prod_d = mul_full(a_q, b_q, op_q[0]);
  end
`endif

  logic unused_stall;
  assign unused_stall = ^{bus.stall[5:3], bus.stall[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Operands and base are captured once at T0 so later input changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      base_q <= '0;
      prod_q <= '0;
      res_q  <= '0;
    end else begin
      if (state_q == S_IDLE && go) begin
        a_q    <= bus.reg1_i;
        b_q    <= bus.reg2_i;
        op_q   <= bus.op;
        base_q <= {bus.hi_i, bus.lo_i};
      end
      prod_q <= prod_d;
      if (state_q == S_ACC) res_q <= res;
    end
  end

  always_comb begin
    state_d        = state_q;
    bus.stallreq_o = 1'b0;
    bus.whilo_o    = 1'b0;
    bus.hi_o       = '0;
    bus.lo_o       = '0;
    bus.cnt_o      = 2'd0;
    case (state_q)
      S_IDLE: begin
        bus.stallreq_o = go;
        if (go) state_d = S_MUL;
      end
      S_MUL: begin
        bus.cnt_o      = 2'd1;
        bus.stallreq_o = ~bus.flush;
`ifdef MADD_SPLIT_MUL_EN
        state_d = bus.flush ? S_IDLE : S_MUL_HI;
`else
        state_d = bus.flush ? S_IDLE : S_ACC;
`endif
      end
      S_MUL_HI: begin
        bus.cnt_o      = 2'd1;
        bus.stallreq_o = ~bus.flush;
        state_d        = bus.flush ? S_IDLE : S_ACC;
      end
      S_ACC: begin
        bus.cnt_o = 2'd2;
        if (!bus.flush) begin
          bus.whilo_o            = 1'b1;
          {bus.hi_o, bus.lo_o}   = res;
        end
        state_d = (!bus.flush && bus.stall[2]) ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        bus.cnt_o = 2'd3;
        if (!bus.flush) begin
          bus.whilo_o            = 1'b1;
          {bus.hi_o, bus.lo_o}   = res_q;
        end
        state_d = (!bus.flush && bus.stall[2]) ? S_HOLD : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ex_madd_unit.sv
// Directed self-checking bench for ex_madd_unit (MADD/MADDU/MSUB/MSUBU,
// flush, HOLD under stall, async reset, back-to-back operations).
module tb_ex_madd_unit;

`ifdef MADD_SPLIT_MUL_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  ex_madd_unit_if #(.DATA_W(32)) bus ();
  ex_madd_unit #(.DATA_W(32)) dut (.clk(clk), .rst(rst_n), .bus(bus));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] op, input logic [31:0] hi, input logic [31:0] lo,
                        input logic [31:0] r1, input logic [31:0] r2);
    bus.op     = op;
    bus.hi_i   = hi;
    bus.lo_i   = lo;
    bus.reg1_i = r1;
    bus.reg2_i = r2;
    bus.start  = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.cnt_o !== 2'd0) begin fails++; $display("FAIL reset_cnt: got %0d want 0", bus.cnt_o); end
    checks++; if ({bus.whilo_o, bus.hi_o, bus.lo_o} !== 65'd0) begin fails++; $display("FAIL reset_hilo: got %b %h %h want 0", bus.whilo_o, bus.hi_o, bus.lo_o); end
    bus.start = 1'b1;
    #1;
    checks++; if (bus.stallreq_o !== 1'b0) begin fails++; $display("FAIL reset_stallreq: got %b want 0", bus.stallreq_o); end
    bus.start = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_madd();
    launch(2'b00, 32'h0, 32'h10, 32'hFFFF_FFFF, 32'h2);
    checks++; if (bus.stallreq_o !== 1'b1) begin fails++; $display("FAIL madd_t0_stallreq: got %b want 1", bus.stallreq_o); end
    checks++; if (bus.cnt_o !== 2'd0 || bus.whilo_o !== 1'b0) begin fails++; $display("FAIL madd_t0_state: cnt %0d whilo %b want 0 0", bus.cnt_o, bus.whilo_o); end
    repeat (LAT - 1) begin
      tick();
      bus.op = 2'b11;
      checks++; if (bus.stallreq_o !== 1'b1 || bus.cnt_o !== 2'd1 || bus.whilo_o !== 1'b0) begin fails++; $display("FAIL madd_mul: stallreq %b cnt %0d whilo %b want 1 1 0", bus.stallreq_o, bus.cnt_o, bus.whilo_o); end
    end
    tick();
    bus.start = 1'b0;
    checks++; if (bus.whilo_o !== 1'b1 || bus.stallreq_o !== 1'b0 || bus.cnt_o !== 2'd2) begin fails++; $display("FAIL madd_acc_ctl: whilo %b stallreq %b cnt %0d want 1 0 2", bus.whilo_o, bus.stallreq_o, bus.cnt_o); end
    checks++; if ({bus.hi_o, bus.lo_o} !== 64'h0000_0000_0000_000E) begin fails++; $display("FAIL madd_result: got %h%h want 000000000000000e", bus.hi_o, bus.lo_o); end
    tick();
    checks++; if (bus.cnt_o !== 2'd0 || bus.whilo_o !== 1'b0 || bus.stallreq_o !== 1'b0) begin fails++; $display("FAIL madd_idle: cnt %0d whilo %b stallreq %b want 0 0 0", bus.cnt_o, bus.whilo_o, bus.stallreq_o); end
  endtask

  task automatic test_maddu();
    launch(2'b01, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (LAT) tick();
    bus.start = 1'b0;
    checks++; if (bus.whilo_o !== 1'b1 || {bus.hi_o, bus.lo_o} !== 64'hFFFF_FFFE_0000_0001) begin fails++; $display("FAIL maddu_result: whilo %b got %h%h want 1 fffffffe00000001", bus.whilo_o, bus.hi_o, bus.lo_o); end
    tick();
  endtask

  task automatic test_msub();
    launch(2'b10, 32'h0, 32'h0, 32'h1, 32'h1);
    repeat (LAT) tick();
    bus.start = 1'b0;
    checks++; if (bus.whilo_o !== 1'b1 || {bus.hi_o, bus.lo_o} !== 64'hFFFF_FFFF_FFFF_FFFF) begin fails++; $display("FAIL msub_wrap: whilo %b got %h%h want 1 ffffffffffffffff", bus.whilo_o, bus.hi_o, bus.lo_o); end
    tick();
  endtask

  task automatic test_msubu();
    launch(2'b11, 32'h0, 32'h5, 32'h2, 32'h3);
    repeat (LAT) tick();
    bus.start = 1'b0;
    checks++; if (bus.whilo_o !== 1'b1 || {bus.hi_o, bus.lo_o} !== 64'hFFFF_FFFF_FFFF_FFFF) begin fails++; $display("FAIL msubu_result: whilo %b got %h%h want 1 ffffffffffffffff", bus.whilo_o, bus.hi_o, bus.lo_o); end
    tick();
  endtask

  task automatic test_flush();
    launch(2'b10, 32'h0, 32'h0, 32'h1, 32'h1);
    tick();
    bus.flush = 1'b1;
    bus.start = 1'b0;
    #1;
    checks++; if (bus.stallreq_o !== 1'b0 || bus.whilo_o !== 1'b0) begin fails++; $display("FAIL flush_cycle: stallreq %b whilo %b want 0 0", bus.stallreq_o, bus.whilo_o); end
    tick();
    bus.flush = 1'b0;
    checks++; if (bus.cnt_o !== 2'd0 || bus.stallreq_o !== 1'b0) begin fails++; $display("FAIL flush_idle: cnt %0d stallreq %b want 0 0", bus.cnt_o, bus.stallreq_o); end
    repeat (3) begin
      tick();
      checks++; if (bus.whilo_o !== 1'b0) begin fails++; $display("FAIL flush_no_write: whilo %b want 0", bus.whilo_o); end
    end
  endtask

  task automatic test_hold();
    launch(2'b01, 32'h1, 32'h1, 32'h3, 32'h4);
    repeat (LAT) tick();
    bus.stall = 6'b000100;
    checks++; if (bus.cnt_o !== 2'd2 || bus.whilo_o !== 1'b1 || {bus.hi_o, bus.lo_o} !== 64'h0000_0001_0000_000D) begin fails++; $display("FAIL hold_acc: cnt %0d whilo %b got %h%h want 2 1 000000010000000d", bus.cnt_o, bus.whilo_o, bus.hi_o, bus.lo_o); end
    tick();
    bus.reg1_i = 32'h55;
    bus.hi_i   = 32'h77;
    checks++; if (bus.cnt_o !== 2'd3 || bus.whilo_o !== 1'b1 || bus.stallreq_o !== 1'b0) begin fails++; $display("FAIL hold_ctl: cnt %0d whilo %b stallreq %b want 3 1 0", bus.cnt_o, bus.whilo_o, bus.stallreq_o); end
    checks++; if ({bus.hi_o, bus.lo_o} !== 64'h0000_0001_0000_000D) begin fails++; $display("FAIL hold_data1: got %h%h want 000000010000000d", bus.hi_o, bus.lo_o); end
    tick();
    checks++; if (bus.cnt_o !== 2'd3 || {bus.hi_o, bus.lo_o} !== 64'h0000_0001_0000_000D) begin fails++; $display("FAIL hold_data2: cnt %0d got %h%h want 3 000000010000000d", bus.cnt_o, bus.hi_o, bus.lo_o); end
    tick();
    bus.stall = 6'b0;
    bus.start = 1'b0;
    checks++; if (bus.cnt_o !== 2'd3 || bus.whilo_o !== 1'b1) begin fails++; $display("FAIL hold_last: cnt %0d whilo %b want 3 1", bus.cnt_o, bus.whilo_o); end
    tick();
    checks++; if (bus.cnt_o !== 2'd0 || bus.whilo_o !== 1'b0 || bus.stallreq_o !== 1'b0) begin fails++; $display("FAIL hold_exit: cnt %0d whilo %b stallreq %b want 0 0 0", bus.cnt_o, bus.whilo_o, bus.stallreq_o); end
  endtask

  task automatic test_back_to_back();
    launch(2'b00, 32'h0, 32'h0, 32'h7, 32'h6);
    repeat (LAT) tick();
    bus.start = 1'b0;
    checks++; if ({bus.hi_o, bus.lo_o} !== 64'h0000_0000_0000_002A) begin fails++; $display("FAIL b2b_first: got %h%h want 000000000000002a", bus.hi_o, bus.lo_o); end
    tick();
    launch(2'b10, 32'h0, 32'h2A, 32'hFFFF_FFFD, 32'h5);
    checks++; if (bus.cnt_o !== 2'd0 || bus.stallreq_o !== 1'b1) begin fails++; $display("FAIL b2b_t0: cnt %0d stallreq %b want 0 1", bus.cnt_o, bus.stallreq_o); end
    repeat (LAT) tick();
    bus.start = 1'b0;
    checks++; if (bus.whilo_o !== 1'b1 || {bus.hi_o, bus.lo_o} !== 64'h0000_0000_0000_0039) begin fails++; $display("FAIL b2b_second: whilo %b got %h%h want 1 0000000000000039", bus.whilo_o, bus.hi_o, bus.lo_o); end
    tick();
    launch(2'b10, 32'h0, 32'h0, 32'h8000_0000, 32'h8000_0000);
    repeat (LAT) tick();
    bus.start = 1'b0;
    checks++; if ({bus.hi_o, bus.lo_o} !== 64'hC000_0000_0000_0000) begin fails++; $display("FAIL b2b_minneg: got %h%h want c000000000000000", bus.hi_o, bus.lo_o); end
    tick();
  endtask

  task automatic test_async_reset();
    launch(2'b00, 32'h0, 32'h0, 32'h2, 32'h3);
    repeat (LAT) tick();
    checks++; if (bus.whilo_o !== 1'b1 || bus.lo_o !== 32'h6) begin fails++; $display("FAIL arst_pre: whilo %b lo %h want 1 00000006", bus.whilo_o, bus.lo_o); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.whilo_o, bus.stallreq_o, bus.cnt_o, bus.hi_o, bus.lo_o} !== 68'd0) begin fails++; $display("FAIL arst_outputs: whilo %b stallreq %b cnt %0d hi %h lo %h want all 0", bus.whilo_o, bus.stallreq_o, bus.cnt_o, bus.hi_o, bus.lo_o); end
    tick();
    rst_n     = 1'b1;
    bus.start = 1'b0;
    tick();
    launch(2'b00, 32'h0, 32'h0, 32'h4, 32'h5);
    checks++; if (bus.cnt_o !== 2'd0 || bus.stallreq_o !== 1'b1) begin fails++; $display("FAIL arst_fresh_t0: cnt %0d stallreq %b want 0 1", bus.cnt_o, bus.stallreq_o); end
    repeat (LAT) tick();
    bus.start = 1'b0;
    checks++; if (bus.whilo_o !== 1'b1 || {bus.hi_o, bus.lo_o} !== 64'h0000_0000_0000_0014) begin fails++; $display("FAIL arst_fresh_result: whilo %b got %h%h want 1 0000000000000014", bus.whilo_o, bus.hi_o, bus.lo_o); end
    tick();
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.flush  = 1'b0;
    bus.stall  = 6'b0;
    bus.start  = 1'b0;
    bus.op     = 2'b00;
    bus.reg1_i = '0;
    bus.reg2_i = '0;
    bus.hi_i   = '0;
    bus.lo_i   = '0;
    test_reset();
    test_madd();
    test_maddu();
    test_msub();
    test_msubu();
    test_flush();
    test_hold();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
